// File: rtl/nand_read_arbiter.sv
// nand_read_arbiter: round-robin arbiter granting two requesters access to a NAND page reader,
// tracking the 512-byte transfer and aborting on ready/strobe timeout.
module nand_read_arbiter #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [14:0] page0,
    input  logic [14:0] page1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic        err_src,
    output logic        rd_start,
    output logic [14:0] rd_page,
    input  logic        rb,
    input  logic        data_en,
    output logic [8:0]  byte_cnt,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, GRANT, START, WAIT_RB, XFER, DONE, ERR} state_t;
    localparam logic [9:0] TMO = 10'(TIMEOUT_CYC);

    state_t      state_q, state_d;
    logic        cur_id_q, cur_id_d, last_q, last_d, err_src_q, err_src_d;
    logic [14:0] rd_page_q, rd_page_d;
    logic [8:0]  byte_cnt_q, byte_cnt_d;
    logic [9:0]  timer_q, timer_d;
    logic        win;

    // on contention the requester not served last wins
    assign win = (req0 & req1) ? ~last_q : req1;

    always_comb begin
        state_d    = state_q;
        cur_id_d   = cur_id_q;
        last_d     = last_q;
        err_src_d  = err_src_q;
        rd_page_d  = rd_page_q;
        byte_cnt_d = byte_cnt_q;
        timer_d    = timer_q;
        unique case (state_q)
            IDLE: if (req0 | req1) begin
                cur_id_d  = win;
                rd_page_d = win ? page1 : page0;
                state_d   = GRANT;
            end
            GRANT: state_d = START;
            START: begin
                timer_d    = '0;
                byte_cnt_d = '0;
                state_d    = WAIT_RB;
            end
            WAIT_RB: if (rb) begin
                timer_d = '0;
                state_d = XFER;
            end else if (timer_q == TMO) begin
                err_src_d = cur_id_q;
                state_d   = ERR;
            end else timer_d = timer_q + 10'd1;
            // a strobe in the timeout cycle still counts and prevents the abort
            XFER: if (data_en) begin
                byte_cnt_d = byte_cnt_q + 9'd1;
                timer_d    = '0;
                state_d    = (byte_cnt_q == 9'd511) ? DONE : XFER;
            end else if (timer_q == TMO) begin
                err_src_d = cur_id_q;
                state_d   = ERR;
            end else timer_d = timer_q + 10'd1;
            DONE: begin
                last_d  = cur_id_q;
                state_d = IDLE;
            end
            ERR: begin
                last_d     = cur_id_q;
                byte_cnt_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_id_q   <= 1'b0;
            last_q     <= 1'b1;
            err_src_q  <= 1'b0;
            rd_page_q  <= '0;
            byte_cnt_q <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_id_q   <= cur_id_d;
            last_q     <= last_d;
            err_src_q  <= err_src_d;
            rd_page_q  <= rd_page_d;
            byte_cnt_q <= byte_cnt_d;
            timer_q    <= timer_d;
        end
    end

    assign gnt0     = (state_q == GRANT) & ~cur_id_q;
    assign gnt1     = (state_q == GRANT) & cur_id_q;
    assign done0    = (state_q == DONE) & ~cur_id_q;
    assign done1    = (state_q == DONE) & cur_id_q;
    assign err      = state_q == ERR;
    assign err_src  = err_src_q;
    assign rd_start = state_q == START;
    assign rd_page  = rd_page_q;
    assign byte_cnt = byte_cnt_q;
    assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_nand_read_arbiter.sv
// tb_nand_read_arbiter: directed/randomized transfers checked against a transaction-level model
// of arbitration, timeouts and byte counting.
module tb_nand_read_arbiter;
    localparam int T = 8;

    logic        clk = 0, rst = 1, req0 = 0, req1 = 0, rb = 0, data_en = 0;
    logic [14:0] page0 = '0, page1 = '0;
    logic        gnt0, gnt1, done0, done1, err, err_src, rd_start, busy;
    logic [14:0] rd_page;
    logic [8:0]  byte_cnt;
    int          errors = 0, checks = 0;
    bit          last = 1;

    nand_read_arbiter #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .page0(page0), .page1(page1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err), .err_src(err_src),
        .rd_start(rd_start), .rd_page(rd_page), .rb(rb), .data_en(data_en),
        .byte_cnt(byte_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_gnt"}, {30'd0, gnt0, gnt1}, 0);
        chk({tag, "_done"}, {30'd0, done0, done1}, 0);
        chk({tag, "_err"}, {30'd0, err, err_src}, 0);
        chk({tag, "_start"}, rd_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_page"}, rd_page, 0);
        chk({tag, "_cnt"}, byte_cnt, 0);
    endtask

    task automatic expect_err(input bit id, input int cnt);
        chk("err_pulse", err, 1);
        chk("err_src", err_src, id);
        chk("err_cnt", byte_cnt, cnt);
        chk("err_nodone", {done0, done1}, 0);
        chk("err_busy", busy, 1);
        data_en = 0;
        step();
        chk("err_one_cycle", err, 0);
        chk("err_idle_busy", busy, 0);
        chk("err_idle_cnt", byte_cnt, 0);
        chk("err_src_held", err_src, id);
        last = id;
    endtask

    // caller sets req0/req1; winner drops its request on grant, the loser keeps it
    task automatic run(input logic [14:0] p0, input logic [14:0] p1, input int rb_d,
                       input int abort_at, input int rst_at);
        bit id;
        int g;
        page0 = p0;
        page1 = p1;
        rb = 0;
        id = (req0 && req1) ? !last : req1;
        step();
        chk("gnt0", gnt0, !id);
        chk("gnt1", gnt1, id);
        chk("grant_busy", busy, 1);
        chk("rd_page", rd_page, id ? p1 : p0);
        chk("grant_nostart", rd_start, 0);
        if (id) req1 = 0; else req0 = 0;
        step();
        chk("rd_start", rd_start, 1);
        chk("start_nognt", {gnt0, gnt1}, 0);
        chk("rd_page_hold", rd_page, id ? p1 : p0);
        step();
        for (int i = 0; i < rb_d; i++) begin
            rb = 0;
            data_en = 1'($urandom);
            step();
            if (i == T) begin
                expect_err(id, 0);
                return;
            end
            chk("wait_noerr", err, 0);
            chk("wait_cnt", byte_cnt, 0);
        end
        rb = 1;
        data_en = 0;
        step();
        chk("xfer_cnt0", byte_cnt, 0);
        for (int b = 0; b < 512; b++) begin
            g = (b == abort_at) ? T + 1 : (b % 50 == 49) ? T : $urandom_range(0, 3);
            for (int j = 0; j < g; j++) begin
                data_en = 0;
                rb = 1'($urandom);
                step();
                if (j == T) begin
                    expect_err(id, b);
                    return;
                end
                chk("gap_cnt", byte_cnt, b);
                chk("gap_noerr", err, 0);
            end
            if (b == rst_at) begin
                #2 rst = 1;
                #1 chk_reset("async_rst");
                req0 = 0;
                req1 = 0;
                data_en = 0;
                step();
                chk_reset("rst_held");
                rst = 0;
                last = 1;
                return;
            end
            data_en = 1;
            rb = 1'($urandom);
            step();
            data_en = 0;
            chk("cnt", byte_cnt, (b + 1) % 512);
            chk("done0", done0, b == 511 && !id);
            chk("done1", done1, b == 511 && id);
        end
        data_en = 1;
        step();
        data_en = 0;
        chk("idle_busy", busy, 0);
        chk("idle_cnt", byte_cnt, 0);
        chk("idle_nodone", {done0, done1}, 0);
        last = id;
    endtask

    initial begin
        repeat (2) step();
        chk_reset("reset");
        rst = 0;
        data_en = 1;
        repeat (2) step();
        data_en = 0;
        chk("idle_stray_cnt", byte_cnt, 0);
        chk("idle_stray_busy", busy, 0);
        req0 = 1;
        run(15'h0123, 15'($urandom), 3, -1, -1);
        req0 = 1; req1 = 1;
        run(15'($urandom), 15'($urandom), 1, -1, -1);
        run(15'($urandom), 15'($urandom), 0, -1, -1);
        req0 = 1; req1 = 1;
        run(15'($urandom), 15'($urandom), T, -1, -1);
        run(15'($urandom), 15'($urandom), 2, -1, -1);
        req0 = 1;
        run(15'($urandom), 15'($urandom), T + 1, -1, -1);
        req1 = 1;
        run(15'($urandom), 15'($urandom), 2, 100, -1);
        req1 = 1;
        run(15'($urandom), 15'($urandom), 1, -1, 300);
        req1 = 1;
        run(15'($urandom), 15'($urandom), 0, -1, -1);
        for (int k = 0; k < 3; k++) begin
            req0 = 1'($urandom);
            req1 = !req0 || 1'($urandom);
            run(15'($urandom), 15'($urandom), $urandom_range(0, T + 1), -1, -1);
            if (req0 | req1) run(15'($urandom), 15'($urandom), 1, -1, -1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nand_read_arbiter.md
NAND_READ_ARBITER -- requirements
Module: nand_read_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1023, is the max wait cycles for ready (rb) or the next byte strobe before abort; range 1..1023.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 req0 / req1  in  1 each  page-read request, level; held by requester until its grant.
REQ-005 page0 / page1  in  15 each  page address of requester 0 / 1; valid while req high.
REQ-006 gnt0 / gnt1  out  1 each  one-cycle grant pulse; requester may drop req in that cycle.
REQ-007 done0 / done1  out  1 each  one-cycle pulse: full 512-byte page delivered for that requester.
REQ-008 err  out  1  one-cycle pulse: current transfer aborted by timeout.
REQ-009 err_src  out  1  id of aborted requester; valid with err, held until next err.
REQ-010 rd_start  out  1  one-cycle start pulse to the flash reader sequencer.
REQ-011 rd_page  out  15  latched page address; stable from grant until return to IDLE.
REQ-012 rb  in  1  flash ready/busy; 1 = ready.
REQ-013 data_en  in  1  byte strobe from the reader, one pulse per byte.
REQ-014 byte_cnt  out  9  bytes received in the current page.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, GRANT, START, WAIT_RB, XFER, DONE, ERR; registered state, one transition per clock.
REQ-017 IDLE: with req0|req1 high, select winner, latch its page into rd_page and its id into cur_id, go to GRANT; else stay.
REQ-018 Arbitration round-robin: only one requesting -> it wins; both -> winner is the id != last_served.
REQ-019 last_served updates to cur_id only on DONE or ERR; reset value 1, so req0 wins the first contention.
REQ-020 GRANT (1 cycle): gnt of cur_id high -> START.
REQ-021 START (1 cycle): rd_start high; timer and byte_cnt cleared -> WAIT_RB.
REQ-022 WAIT_RB: rb==1 -> XFER with timer cleared; else timer increments; timer==TIMEOUT_CYC with rb==0 -> ERR.
REQ-023 XFER: data_en increments byte_cnt and clears timer; no data_en increments timer.
REQ-024 XFER: data_en while byte_cnt==511 -> DONE, byte_cnt wraps to 0 (9-bit wrap, no 513th count).
REQ-025 XFER: timer==TIMEOUT_CYC with data_en low -> ERR; data_en in the same cycle takes priority (counted, no abort).
REQ-026 DONE (1 cycle): done of cur_id high -> IDLE; ERR (1 cycle): err high, err_src=cur_id, byte_cnt cleared -> IDLE.
REQ-027 data_en outside XFER ignored; rb ignored outside WAIT_RB.
REQ-028 req sampled only in IDLE; req still high after DONE/ERR is treated as a new request.
REQ-029 Latency: req seen in IDLE -> gnt next cycle -> rd_start the cycle after.
REQ-030 All outputs registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-031 rst high forces IDLE immediately from any state, including mid-XFER; no done/err pulse is generated for the aborted transfer.
REQ-032 Reset values: gnt0/1, done0/1, err, err_src, rd_start, busy = 0; rd_page = 0; byte_cnt = 0; timer = 0; last_served = 1.
REQ-033 After rst release the first request is evaluated on the first clock edge in IDLE.

Verification
REQ-034 req0=1, page0=15'h0123, rb=1 after 3 cycles, 512 data_en pulses -> gnt0, rd_start, rd_page=0x0123, byte_cnt 0..511, done0 one cycle after the 512th strobe.
REQ-035 req0 and req1 high together, repeated three times -> grants in order 0,1,0; each done matches its grant id.
REQ-036 TIMEOUT_CYC=8, rb held 0 -> err pulse 8 cycles after entering WAIT_RB with err_src=cur_id; no done; busy drops next cycle.
REQ-037 TIMEOUT_CYC=8, 100 strobes then silence -> err after 8 idle cycles; byte_cnt=100 at abort, then 0; a strobe arriving on cycle 8 prevents the abort.
REQ-038 rst pulsed at byte 300 -> all outputs at reset values asynchronously; next req1 gets gnt1 and a full 512-byte page.
REQ-039 Extra data_en in IDLE/DONE and rb toggling in XFER -> byte_cnt and state unaffected.
